eight_way_grant_scheduler: RTL and testbench

EIGHT_WAY_GRANT_SCHEDULER -- requirements
Module: eight_way_grant_scheduler

---
 rtl/eight_way_grant_scheduler_pkg.sv | 20 ++
 rtl/eight_way_grant_scheduler_demux.sv | 27 ++
 rtl/eight_way_grant_scheduler.sv | 119 +++++++++++
 tb/tb_eight_way_grant_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/eight_way_grant_scheduler_pkg.sv
// Shared definitions for the eight-way grant scheduler.
// Holds the FSM state encoding and the default hold limit so that the
// RTL and anything that talks to it agree on the same values.
package eight_way_grant_scheduler_pkg;

  // Scheduler FSM states; encodings are fixed so external tools can
  // decode the state value consistently.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  // Default maximum number of consecutive grant cycles per tenure.
  localparam int MAX_HOLD_DEFAULT = 4;

  // Number of requesters served by the scheduler.
  localparam int NUM_REQ = 8;

endpackage

// File: rtl/eight_way_grant_scheduler_demux.sv
// threeToEightDEMUX: 3-to-8 line decoder with active-low outputs.
// Behaves like a classic '138 part: one active-high enable and two
// active-low enables must all be asserted for a single output to go low.
//
// Ports:
//   g1  - active-high enable
//   g2a - active-low enable
//   g2b - active-low enable
//   S   - 3-bit select
//   D   - 8-bit active-low decoded output (all 1s when disabled)
module threeToEightDEMUX (
  input  logic       g1,
  input  logic       g2a,
  input  logic       g2b,
  input  logic [2:0] S,
  output logic [7:0] D
);

  // Drive the selected line low only when every enable is asserted.
  always_comb begin
    D = 8'hFF;
    if (g1 && !g2a && !g2b) begin
      D[S] = 1'b0;
    end
  end

endmodule

// File: rtl/eight_way_grant_scheduler.sv
// eight_way_grant_scheduler: round-robin arbiter for eight requesters with
// a bounded tenure and a mandatory dead cycle between tenures.
//
// Ports:
//   clk       - single clock, rising-edge active
//   rst       - synchronous active-high reset
//   en        - scheduler enable; low blocks new grants and ends a tenure
//   req[7:0]  - active-high request lines, bit i is requester i
//   gnt_n     - active-low one-cold grant lines (8'hFF when nothing granted)
//   gnt_idx   - index of current grantee, meaningful while gnt_valid=1
//   gnt_valid - high while a grant is active
//   busy      - high while granting or in the dead cycle after a tenure
module eight_way_grant_scheduler
  import eight_way_grant_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt_n,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       busy
);

  // Last cycle count of a tenure; cnt reaches this value on the final
  // grant cycle, so a 4-bit counter never has to wrap.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  sched_state_t state, state_next;
  logic [2:0]   ptr, ptr_next;
  logic [2:0]   idx_q, idx_next;
  logic [3:0]   cnt, cnt_next;

  logic         found;
  logic [2:0]   sel;

  // Round-robin search: the first set request at or above ptr, wrapping
  // 7->0. Scanning from the farthest offset down lets the nearest hit
  // overwrite earlier ones, so the closest requester to ptr wins.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + 3'(k)]) begin
        found = 1'b1;
        sel   = ptr + 3'(k);
      end
    end
  end

  // Next-state logic. A tenure ends when the grantee drops its request,
  // the hold limit is reached, or the scheduler is disabled; the pointer
  // then moves one past the grantee so the next search starts there.
  // Other requesters' bits are only looked at during arbitration.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    idx_next   = idx_q;
    cnt_next   = cnt;

    unique case (state)
      IDLE, GAP: begin
        if (en && found) begin
          state_next = GRANT;
          idx_next   = sel;
          cnt_next   = 4'd0;
        end else begin
          state_next = IDLE;
        end
      end

      GRANT: begin
        if (!req[idx_q] || (cnt == HOLD_LAST) || !en) begin
          state_next = GAP;
          ptr_next   = idx_q + 3'd1;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. Reset wins over everything, including mid-tenure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      idx_q <= 3'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      idx_q <= idx_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs come purely from registered state, so gnt_n cannot glitch on
  // req or en changes.
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state == GRANT);
  assign busy      = (state == GRANT) || (state == GAP);

  threeToEightDEMUX u_demux (
    .g1  (gnt_valid),
    .g2a (1'b0),
    .g2b (1'b0),
    .S   (idx_q),
    .D   (gnt_n)
  );

endmodule

// File: tb/tb_eight_way_grant_scheduler.sv
// Self-checking bench for eight_way_grant_scheduler. A tenure-level
// reference model (who owns the grant, how many cycles it has held, and
// where the next search starts) predicts every output cycle by cycle.
module tb_eight_way_grant_scheduler;
  import eight_way_grant_scheduler_pkg::*;

  localparam int HOLD = MAX_HOLD_DEFAULT;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt_n;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;

  int checks;
  int failures;

  // Reference model: tenure-level view of the scheduler
  bit m_granting;
  bit m_in_gap;
  bit m_just_reset;
  int m_owner;
  int m_held;
  int m_next_start;

  // Rotation tracking
  int  starts[$];
  bit  prev_valid;

  eight_way_grant_scheduler #(.MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .busy      (busy)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the reference model by one clock edge using the inputs that
  // were stable at that edge.
  task automatic modelStep(input bit r, input bit e, input logic [7:0] rq);
    m_just_reset = 1'b0;
    if (r) begin
      m_granting   = 1'b0;
      m_in_gap     = 1'b0;
      m_owner      = 0;
      m_held       = 0;
      m_next_start = 0;
      m_just_reset = 1'b1;
    end else if (m_granting) begin
      if (!rq[m_owner] || !e || m_held == HOLD) begin
        m_granting   = 1'b0;
        m_in_gap     = 1'b1;
        m_next_start = (m_owner + 1) % 8;
      end else begin
        m_held = m_held + 1;
      end
    end else begin
      m_in_gap = 1'b0;
      if (e && rq != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (!m_granting && rq[(m_next_start + k) % 8]) begin
            m_owner    = (m_next_start + k) % 8;
            m_granting = 1'b1;
            m_held     = 1;
          end
        end
      end
    end
  endtask

  // Compare DUT outputs against the model
  task automatic checkOutput(input string tag);
    logic [7:0] onehot;
    logic [7:0] exp_gnt_n;
    onehot    = 8'd1 << m_owner;
    exp_gnt_n = m_granting ? ~onehot : 8'hFF;

    checks++;
    assert (gnt_n === exp_gnt_n)
      else begin
        failures++;
        $error("[TB] FAIL %s gnt_n: got %h expected %h", tag, gnt_n, exp_gnt_n);
      end

    checks++;
    assert (gnt_valid === m_granting)
      else begin
        failures++;
        $error("[TB] FAIL %s gnt_valid: got %b expected %b", tag, gnt_valid, m_granting);
      end

    checks++;
    assert (busy === (m_granting || m_in_gap))
      else begin
        failures++;
        $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, (m_granting || m_in_gap));
      end

    if (m_granting || m_just_reset) begin
      checks++;
      assert (gnt_idx === 3'(m_owner))
        else begin
          failures++;
          $error("[TB] FAIL %s gnt_idx: got %0d expected %0d", tag, gnt_idx, m_owner);
        end
    end
  endtask

  // Drive inputs, clock one edge, update the model, then sample #1 later
  task automatic applyStimulus(input bit r, input bit e, input logic [7:0] rq, input string tag);
    rst = r;
    en  = e;
    req = rq;
    @(posedge clk);
    modelStep(r, e, rq);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    m_granting   = 1'b0;
    m_in_gap     = 1'b0;
    m_just_reset = 1'b0;
    m_owner      = 0;
    m_held       = 0;
    m_next_start = 0;
    prev_valid   = 1'b0;
    rst = 1'b1;
    en  = 1'b0;
    req = 8'h00;

    // Reset held two cycles with every requester active
    applyStimulus(1, 1, 8'hFF, "reset0");
    applyStimulus(1, 1, 8'hFF, "reset1");

    // Single requester 3: four grant cycles, one gap, regrant
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'h08, "single");

    // Early release: requester 0 drops after two grant cycles, 5 follows
    applyStimulus(1, 0, 8'h00, "rst_early");
    applyStimulus(0, 1, 8'h21, "early_arb");
    applyStimulus(0, 1, 8'h21, "early_hold");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 8'h20, "early_rel");

    // Full rotation with all requesters active
    applyStimulus(1, 0, 8'h00, "rst_rot");
    prev_valid = 1'b0;
    starts.delete();
    for (int i = 0; i < 42; i++) begin
      applyStimulus(0, 1, 8'hFF, "rotate");
      if (gnt_valid && !prev_valid) starts.push_back(int'(gnt_idx));
      prev_valid = gnt_valid;
    end
    checks++;
    assert (starts.size() >= 9)
      else begin
        failures++;
        $error("[TB] FAIL rotate_count: got %0d expected >=9", starts.size());
      end
    for (int i = 0; i < 9 && i < starts.size(); i++) begin
      checks++;
      assert (starts[i] === (i % 8))
        else begin
          failures++;
          $error("[TB] FAIL rotate_order[%0d]: got %0d expected %0d", i, starts[i], i % 8);
        end
    end

    // Disable mid-tenure on requester 2, then re-enable: search from 3
    applyStimulus(1, 0, 8'h00, "rst_dis");
    applyStimulus(0, 1, 8'h04, "dis_arb");
    applyStimulus(0, 1, 8'h04, "dis_hold");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'hFF, "dis_off");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hFF, "dis_on");

    // Reset in the middle of a tenure on requester 6
    applyStimulus(1, 0, 8'h00, "rst_mid0");
    applyStimulus(0, 1, 8'h40, "mid_arb");
    applyStimulus(0, 1, 8'h40, "mid_hold");
    applyStimulus(1, 1, 8'hC0, "mid_rst");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hC0, "mid_after");

    // Randomized traffic with occasional reset and disable
    for (int i = 0; i < 400; i++) begin
      bit          r;
      bit          e;
      logic [7:0]  rq;
      r  = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 7) != 0);
      rq = 8'($urandom);
      if ($urandom_range(0, 2) == 0) rq = rq & 8'($urandom);
      applyStimulus(r, e, rq, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
